alu_seq_ctrl: RTL and testbench
===============================

# alu_seq_ctrl

Multi-cycle sequencer wrapped around the combinational 16-bit ALU. Accepts one ALU request per transaction over a valid/ready handshake, drives the ALU operand, opcode and carry-in ports, and holds the processor status register (PSR). Updates the PSR with a per-opcode mask and returns results to register-file writeback over a second valid/ready handshake. Sits between decode/issue and the register file; the ALU itself stays outside this block.

## Interface
- WIDTH, 16, datapath width; must match the ALU.
- MUL_LAT, 2, extra wait cycles for MUL; used only when ALU_MUL_WAIT_EN is defined; legal range 1..15.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; equals (state==IDLE) & ~reset.
- req_op  in  5  ALU opcode, 0..9 legal.
- req_a  in  WIDTH  Rdest operand.
- req_b  in  WIDTH  Rsrc operand.
- req_dest  in  4  destination register index.
- alu_a, alu_b  out  WIDTH  ALU operands, driven from latched request.
- alu_op  out  5  ALU opcode, driven from latched request.
- alu_c  out  1  ALU carry-in; equals psr[0].
- alu_result  in  WIDTH  ALU result.
- alu_codes  in  5  ALU condition codes {N,Z,F,L,C}.
- wb_valid  out  1  writeback data available.
- wb_ready  in  1  register file accepts writeback.
- wb_data  out  WIDTH  captured result.
- wb_dest  out  4  captured destination index.
- psr  out  5  status flags {N,Z,F,L,C}; bit 4 = N, bit 0 = C.
- illegal  out  1  one-cycle pulse when the opcode is greater than 9.

## Operation
- States:
  - IDLE: req_ready=1. On req_valid, latch op, a, b and dest, then go to EXEC.
  - EXEC: one cycle with the ALU inputs stable. At the clock edge:
    - Capture alu_result into wb_data.
    - Apply the PSR mask.
    - MUL with ALU_MUL_WAIT_EN defined: go to MWAIT.
    - CMP or illegal opcode: go to IDLE.
    - All other opcodes: go to WB.
  - MWAIT: a down-counter loaded with MUL_LAT. At zero, recapture alu_result, then go to WB.
  - WB: wb_valid=1. wb_data and wb_dest are held stable until wb_ready. On wb_valid&wb_ready, go to IDLE.
- PSR update mask, applied at the end of EXEC:
  - CMP(0) writes all 5 bits.
  - ADD(3), ADDC(4), SUB(5) and SUBC(6) write F and C only; N, Z and L are retained.
  - AND, OR, XOR, MUL, NOT and illegal opcodes write nothing.
- Carry: alu_c is always psr[0]. ADDC and SUBC therefore consume the C flag left by the previous flag-writing op.
- Illegal opcode (>9): illegal=1 in the EXEC cycle; no PSR write and no writeback.
- Only one request is in flight at a time. No request is accepted outside IDLE, and req_valid outside IDLE is ignored.
- Reset values: state IDLE, psr=0, wb_valid=0, wb_data=0, wb_dest=0, illegal=0, latched operands and opcode=0 (so alu_op=0, alu_a=0, alu_b=0), MWAIT counter=0.
- Reset mid-operation: the in-flight request is dropped with no writeback. PSR is cleared even if the EXEC edge coincides with reset.

## Timing
- Cycle 0: handshake (req_valid&req_ready).
- Cycle 1: EXEC.
- Cycle 2: wb_valid rises (or cycle 2+MUL_LAT for MUL with the macro defined).
- The PSR reflects the new flags from cycle 2.
- Minimum issue interval is 3 cycles with wb_ready held at 1. CMP takes 2 cycles.
- wb_valid must not drop, and wb_data/wb_dest must not change, until accepted.

## Configuration
- ALU_MUL_WAIT_EN defined: MUL passes through MWAIT for MUL_LAT cycles before capture. This supports a multicycle-path constrained multiplier.
- Not defined: the MWAIT state and counter are absent, MUL behaves like any other writeback op, and MUL_LAT is ignored.

## Structure
- Shared package alu_pkg holds:
  - opcode localparams OP_CMP=0 … OP_NOT=9;
  - flag bit indices FLG_N=4, FLG_Z=3, FLG_F=2, FLG_L=1, FLG_C=0;
  - the state enum;
  - the function returning the 5-bit PSR write mask per opcode.
- One sub-module, psr_update: the PSR register with per-bit masked write and async reset.

## Test plan
- ADD a=0x0003 b=0x0004 dest=2, wb_ready=1 -> wb_valid in cycle 2 with wb_data=0x0007 and wb_dest=2; psr N, Z and L unchanged.
- CMP a=0x0005 b=0x0005 -> no wb_valid, psr=5'b01000. Then CMP a=0x0001 b=0x0002 -> psr=5'b10010.
- ADD with wb_ready=0 for 5 cycles -> wb_valid, wb_data and wb_dest stable; req_ready=0; a req_valid pulse during the stall is not accepted.
- Opcode 12 -> illegal=1 for exactly one cycle, psr unchanged, no wb_valid, back in IDLE in cycle 2.
- MUL a=0x0003 b=0x0005 -> wb_data=0x000F. With ALU_MUL_WAIT_EN and MUL_LAT=2, wb_valid rises in cycle 4; without the macro, in cycle 2.
- reset asserted during WB -> wb_valid drops asynchronously, psr=0, req_ready=1 in the first cycle after reset release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, PSR flag indices,
// controller state encoding and the per-opcode PSR write mask.
package alu_pkg;

    localparam logic [4:0] OP_CMP  = 5'd0;
    localparam logic [4:0] OP_AND  = 5'd1;
    localparam logic [4:0] OP_OR   = 5'd2;
    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_ADDC = 5'd4;
    localparam logic [4:0] OP_SUB  = 5'd5;
    localparam logic [4:0] OP_SUBC = 5'd6;
    localparam logic [4:0] OP_XOR  = 5'd7;
    localparam logic [4:0] OP_MUL  = 5'd8;
    localparam logic [4:0] OP_NOT  = 5'd9;

    localparam int unsigned FLG_N = 4;
    localparam int unsigned FLG_Z = 3;
    localparam int unsigned FLG_F = 2;
    localparam int unsigned FLG_L = 1;
    localparam int unsigned FLG_C = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_MWAIT = 2'd2,
        ST_WB    = 2'd3
    } state_t;

    function automatic logic op_legal(input logic [4:0] op);
        return op <= OP_NOT;
    endfunction

    // Bits set here are overwritten from the ALU condition codes; all others retained.
    function automatic logic [4:0] psr_wr_mask(input logic [4:0] op);
        logic [4:0] m;
        m = '0;
        case (op)
            OP_CMP: m = '1;
            OP_ADD, OP_ADDC, OP_SUB, OP_SUBC: begin
                m[FLG_F] = 1'b1;
                m[FLG_C] = 1'b1;
            end
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Request, writeback and ALU-side signal bundle for alu_seq_ctrl.
// The slave modport is the sequencer; the master modport is its environment.
interface alu_seq_ctrl_if #(
    parameter int unsigned WIDTH = 16
);
    logic             req_valid;
    logic             req_ready;
    logic [4:0]       req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [3:0]       req_dest;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [4:0]       alu_op;
    logic             alu_c;
    logic [WIDTH-1:0] alu_result;
    logic [4:0]       alu_codes;

    logic             wb_valid;
    logic             wb_ready;
    logic [WIDTH-1:0] wb_data;
    logic [3:0]       wb_dest;

    modport master (
        output req_valid, req_op, req_a, req_b, req_dest,
        output alu_result, alu_codes, wb_ready,
        input  req_ready, alu_a, alu_b, alu_op, alu_c,
        input  wb_valid, wb_data, wb_dest
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_dest,
        input  alu_result, alu_codes, wb_ready,
        output req_ready, alu_a, alu_b, alu_op, alu_c,
        output wb_valid, wb_data, wb_dest
    );

endinterface

// File: rtl/alu_seq_ctrl_psr_update.sv
// Processor status register with per-bit masked write and async reset.
module psr_update (
    input  logic       clk,
    input  logic       reset,
    input  logic       we,
    input  logic [4:0] mask,
    input  logic [4:0] din,
    output logic [4:0] psr
);

    logic [4:0] psr_q;
    logic [4:0] psr_d;

    always_comb begin
        psr_d = psr_q;
        if (we) begin
            psr_d = (psr_q & ~mask) | (din & mask);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            psr_q <= '0;
        end else begin
            psr_q <= psr_d;
        end
    end

    assign psr = psr_q;

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle sequencer around the external 16-bit ALU with PSR and writeback handshake.
// Optional macro ALU_MUL_WAIT_EN: MUL waits MUL_LAT extra cycles in MWAIT before capture.
import alu_pkg::*;

module alu_seq_ctrl #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned MUL_LAT = 2
) (
    input  logic            clk,
    input  logic            reset,
    alu_seq_ctrl_if.slave   bus,
    output logic [4:0]      psr,
    output logic            illegal
);

    if (MUL_LAT < 1 || MUL_LAT > 15) begin : g_bad_mul_lat
        $error("alu_seq_ctrl: MUL_LAT must be in 1..15");
    end

    state_t           state_q, state_d;
    logic [4:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [3:0]       dest_q, dest_d;
    logic [WIDTH-1:0] wb_data_q, wb_data_d;
    logic [3:0]       wb_dest_q, wb_dest_d;
    logic             wb_valid_q, wb_valid_d;
    logic             illegal_q, illegal_d;
`ifdef ALU_MUL_WAIT_EN
    logic [3:0]       cnt_q, cnt_d;
`endif

    logic             psr_we;
    logic [4:0]       psr_mask;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        dest_d     = dest_q;
        wb_data_d  = wb_data_q;
        wb_dest_d  = wb_dest_q;
        wb_valid_d = wb_valid_q;
        illegal_d  = 1'b0;
        psr_we     = 1'b0;
        psr_mask   = psr_wr_mask(op_q);
`ifdef ALU_MUL_WAIT_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    op_d      = bus.req_op;
                    a_d       = bus.req_a;
                    b_d       = bus.req_b;
                    dest_d    = bus.req_dest;
                    illegal_d = !op_legal(bus.req_op);
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                wb_data_d = bus.alu_result;
                wb_dest_d = dest_q;
                psr_we    = 1'b1;
                if (!op_legal(op_q) || op_q == OP_CMP) begin
                    state_d = ST_IDLE;
`ifdef ALU_MUL_WAIT_EN
                end else if (op_q == OP_MUL) begin
                    cnt_d   = 4'(MUL_LAT);
                    state_d = ST_MWAIT;
`endif
                end else begin
                    wb_valid_d = 1'b1;
                    state_d    = ST_WB;
                end
            end
            ST_MWAIT: begin
`ifdef ALU_MUL_WAIT_EN
                // Leave on the edge that takes the counter to zero so MWAIT lasts exactly MUL_LAT cycles.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    wb_data_d  = bus.alu_result;
                    wb_valid_d = 1'b1;
                    state_d    = ST_WB;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_WB: begin
                if (bus.wb_ready) begin
                    wb_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            dest_q     <= '0;
            wb_data_q  <= '0;
            wb_dest_q  <= '0;
            wb_valid_q <= 1'b0;
            illegal_q  <= 1'b0;
`ifdef ALU_MUL_WAIT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            dest_q     <= dest_d;
            wb_data_q  <= wb_data_d;
            wb_dest_q  <= wb_dest_d;
            wb_valid_q <= wb_valid_d;
            illegal_q  <= illegal_d;
`ifdef ALU_MUL_WAIT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    psr_update u_psr (
        .clk   (clk),
        .reset (reset),
        .we    (psr_we),
        .mask  (psr_mask),
        .din   (bus.alu_codes),
        .psr   (psr)
    );

    assign bus.req_ready = (state_q == ST_IDLE) && !reset;
    assign bus.alu_a     = a_q;
    assign bus.alu_b     = b_q;
    assign bus.alu_op    = op_q;
    assign bus.alu_c     = psr[FLG_C];
    assign bus.wb_valid  = wb_valid_q;
    assign bus.wb_data   = wb_data_q;
    assign bus.wb_dest   = wb_dest_q;
    assign illegal       = illegal_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl with a behavioural ALU and PSR reference model.
module tb_alu_seq_ctrl;

    localparam int unsigned MUL_LAT = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] psr;
    logic       illegal;
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    int unsigned cyc = 0;
    logic [4:0] m_psr = '0;

    alu_seq_ctrl_if #(.WIDTH(16)) bus ();

    alu_seq_ctrl #(.WIDTH(16), .MUL_LAT(MUL_LAT)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .psr     (psr),
        .illegal (illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Behavioural ALU: {N,Z,F,L,C, result}
    function automatic logic [20:0] alu_eval(input logic [4:0] op, input logic [15:0] a,
                                             input logic [15:0] b, input logic c);
        logic [16:0] s;
        logic [31:0] p;
        logic [15:0] r;
        logic [4:0]  f;
        s = '0; p = '0; r = '0; f = '0;
        case (op)
            5'd0: begin
                f[4] = $signed(a) < $signed(b);
                f[3] = (a == b);
                f[1] = (a < b);
            end
            5'd1: r = a & b;
            5'd2: r = a | b;
            5'd3, 5'd4: begin
                s = {1'b0, a} + {1'b0, b} + ((op == 5'd4) ? {16'd0, c} : 17'd0);
                r = s[15:0];
                f[0] = s[16];
                f[2] = (a[15] == b[15]) && (r[15] != a[15]);
            end
            5'd5, 5'd6: begin
                s = {1'b0, a} - {1'b0, b} - ((op == 5'd6) ? {16'd0, c} : 17'd0);
                r = s[15:0];
                f[0] = s[16];
                f[2] = (a[15] != b[15]) && (r[15] != a[15]);
            end
            5'd7: r = a ^ b;
            5'd8: begin p = {16'd0, a} * {16'd0, b}; r = p[15:0]; end
            5'd9: r = ~a;
            default: r = 16'hDEAD;
        endcase
        if (op != 5'd0) begin
            // Non-compare codes carry junk-ish flags so masking errors are visible.
            f[4] = r[15];
            f[3] = (r == 16'd0);
            f[1] = r[0];
            if (op < 5'd3 || op > 5'd6) begin f[2] = r[1]; f[0] = r[2]; end
        end
        return {f, r};
    endfunction

    always_comb {bus.alu_codes, bus.alu_result} = alu_eval(bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_c);

    task automatic model_psr(input logic [4:0] op, input logic [4:0] codes);
        if (op == 5'd0) m_psr = codes;
        else if (op >= 5'd3 && op <= 5'd6) begin
            m_psr[2] = codes[2];
            m_psr[0] = codes[0];
        end
    endtask

    // Starts and ends at a negedge with the DUT idle.
    task automatic run_txn(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic [3:0] dest, input int unsigned stall);
        logic [20:0] r;
        bit          wb_exp;
        int unsigned lat_exp;
        int unsigned lat;
        r = alu_eval(op, a, b, m_psr[0]);
        wb_exp = (op != 5'd0) && (op <= 5'd9);
        lat_exp = 2;
`ifdef ALU_MUL_WAIT_EN
        if (op == 5'd8) lat_exp = 2 + MUL_LAT;
`endif
        n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready op=%0d got=%b exp=1", op, bus.req_ready); end
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_a = a; bus.req_b = b; bus.req_dest = dest;
        bus.wb_ready = (stall == 0);
        @(negedge clk);
        bus.req_valid = 1'b0; bus.req_op = 5'($urandom); bus.req_a = 16'($urandom); bus.req_b = 16'($urandom);
        bus.req_dest = 4'($urandom);
        n_checks++; if (illegal !== (op > 5'd9)) begin n_fail++; $display("FAIL exec_illegal op=%0d got=%b exp=%b", op, illegal, op > 5'd9); end
        n_checks++; if ({bus.alu_op, bus.alu_a, bus.alu_b} !== {op, a, b}) begin n_fail++;
            $display("FAIL exec_operands got=%0d/%h/%h exp=%0d/%h/%h", bus.alu_op, bus.alu_a, bus.alu_b, op, a, b); end
        n_checks++; if (bus.alu_c !== m_psr[0] || psr !== m_psr) begin n_fail++;
            $display("FAIL exec_psr got=%b c=%b exp=%b", psr, bus.alu_c, m_psr); end
        n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL exec_ready got=%b exp=0", bus.req_ready); end
        model_psr(op, r[20:16]);
        lat = 1;
        if (wb_exp) begin
            do begin
                @(negedge clk);
                lat++;
            end while (bus.wb_valid !== 1'b1 && lat < 40);
            n_checks++; if (lat != lat_exp) begin n_fail++; $display("FAIL wb_latency op=%0d got=%0d exp=%0d", op, lat, lat_exp); end
            n_checks++; if (bus.wb_data !== r[15:0] || bus.wb_dest !== dest) begin n_fail++;
                $display("FAIL wb_payload op=%0d got=%h/%0d exp=%h/%0d", op, bus.wb_data, bus.wb_dest, r[15:0], dest); end
            n_checks++; if (psr !== m_psr) begin n_fail++; $display("FAIL wb_psr op=%0d got=%b exp=%b", op, psr, m_psr); end
            for (int i = 0; i < int'(stall); i++) begin
                bus.req_valid = 1'b1; bus.req_op = 5'd3;
                n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready got=%b exp=0", bus.req_ready); end
                @(negedge clk);
                n_checks++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== r[15:0] || bus.wb_dest !== dest) begin n_fail++;
                    $display("FAIL stall_hold got=%b/%h/%0d exp=1/%h/%0d", bus.wb_valid, bus.wb_data, bus.wb_dest, r[15:0], dest); end
            end
            bus.req_valid = 1'b0; bus.wb_ready = 1'b1;
        end
        @(negedge clk);
        n_checks++; if (bus.wb_valid !== 1'b0 || bus.req_ready !== 1'b1 || illegal !== 1'b0) begin n_fail++;
            $display("FAIL back_to_idle op=%0d got wb_valid=%b ready=%b illegal=%b exp 0/1/0", op, bus.wb_valid, bus.req_ready, illegal); end
        n_checks++; if (psr !== m_psr) begin n_fail++; $display("FAIL idle_psr op=%0d got=%b exp=%b", op, psr, m_psr); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.req_valid = 1'b1; bus.req_op = 5'd3; bus.req_a = 16'h1111; bus.req_b = 16'h2222; bus.req_dest = 4'd7;
        bus.wb_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if ({bus.wb_valid, bus.wb_data, bus.wb_dest, psr, illegal} !== '0) begin n_fail++;
            $display("FAIL reset_outputs got=%b/%h/%0d/%b/%b exp all zero", bus.wb_valid, bus.wb_data, bus.wb_dest, psr, illegal); end
        n_checks++; if ({bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_c} !== '0) begin n_fail++;
            $display("FAIL reset_alu got=%0d/%h/%h/%b exp zero", bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_c); end
        n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", bus.req_ready); end
        bus.req_valid = 1'b0;
        reset = 1'b0;
        m_psr = '0;
        @(negedge clk);
    endtask

    task automatic test_add();
        run_txn(5'd3, 16'h0003, 16'h0004, 4'd2, 0);
        n_checks++; if (psr !== 5'b00000) begin n_fail++; $display("FAIL add_psr got=%b exp=00000", psr); end
    endtask

    task automatic test_cmp();
        run_txn(5'd0, 16'h0005, 16'h0005, 4'd1, 0);
        n_checks++; if (psr !== 5'b01000) begin n_fail++; $display("FAIL cmp_eq_psr got=%b exp=01000", psr); end
        run_txn(5'd0, 16'h0001, 16'h0002, 4'd1, 0);
        n_checks++; if (psr !== 5'b10010) begin n_fail++; $display("FAIL cmp_lt_psr got=%b exp=10010", psr); end
    endtask

    task automatic test_stall();
        run_txn(5'd3, 16'hFFFF, 16'h0002, 4'd9, 5);
        n_checks++; if (psr !== 5'b10011) begin n_fail++; $display("FAIL stall_add_psr got=%b exp=10011", psr); end
        run_txn(5'd4, 16'h0010, 16'h0001, 4'd3, 0);
    endtask

    task automatic test_illegal();
        run_txn(5'd12, 16'h00AA, 16'h0055, 4'd4, 0);
        run_txn(5'd31, 16'hFFFF, 16'hFFFF, 4'd15, 0);
    endtask

    task automatic test_mul();
        run_txn(5'd8, 16'h0003, 16'h0005, 4'd6, 0);
        n_checks++; if (bus.wb_data !== 16'h000F) begin n_fail++; $display("FAIL mul_data got=%h exp=000f", bus.wb_data); end
        run_txn(5'd8, 16'h1234, 16'h00FF, 4'd11, 2);
    endtask

    task automatic test_back_to_back();
        int unsigned t0, t1, t2, t3;
        t0 = cyc; run_txn(5'd5, 16'h0001, 16'h0003, 4'd1, 0);
        t1 = cyc; run_txn(5'd6, 16'h0009, 16'h0002, 4'd2, 0);
        t2 = cyc; run_txn(5'd0, 16'h8000, 16'h0001, 4'd3, 0);
        t3 = cyc;
        n_checks++; if ((t1 - t0) != 3 || (t2 - t1) != 3 || (t3 - t2) != 2) begin n_fail++;
            $display("FAIL issue_interval got=%0d/%0d/%0d exp=3/3/2", t1 - t0, t2 - t1, t3 - t2); end
    endtask

    task automatic test_random();
        logic [4:0] op;
        for (int i = 0; i < 60; i++) begin
            op = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(10, 31)) : 5'($urandom_range(0, 9));
            run_txn(op, 16'($urandom), 16'($urandom), 4'($urandom), $urandom_range(0, 2));
        end
    endtask

    task automatic test_reset_mid();
        run_txn(5'd0, 16'h0001, 16'h0002, 4'd0, 0);
        bus.req_valid = 1'b1; bus.req_op = 5'd3; bus.req_a = 16'h1234; bus.req_b = 16'h0001; bus.req_dest = 4'd5;
        bus.wb_ready = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.wb_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_wb got=%b exp=1", bus.wb_valid); end
        #2 reset = 1'b1;
        #1;
        n_checks++; if (bus.wb_valid !== 1'b0 || psr !== 5'b00000) begin n_fail++;
            $display("FAIL async_reset got wb_valid=%b psr=%b exp 0/00000", bus.wb_valid, psr); end
        @(negedge clk);
        reset = 1'b0; m_psr = '0; bus.wb_ready = 1'b1;
        #1;
        n_checks++; if (bus.req_ready !== 1'b1 || bus.wb_valid !== 1'b0) begin n_fail++;
            $display("FAIL post_reset got ready=%b wb_valid=%b exp 1/0", bus.req_ready, bus.wb_valid); end
        @(negedge clk);
        n_checks++; if (bus.wb_valid !== 1'b0 || psr !== 5'b00000) begin n_fail++;
            $display("FAIL post_reset_hold got wb_valid=%b psr=%b exp 0/00000", bus.wb_valid, psr); end
        run_txn(5'd4, 16'h0002, 16'h0002, 4'd8, 0);
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0; bus.req_dest = '0; bus.wb_ready = 1'b1;
        test_reset();
        test_add();
        test_cmp();
        test_stall();
        test_illegal();
        test_mul();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
